// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM state
// encoding, frame geometry, default timing and frame construction.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_REQ     = 3'd2,
        ST_SEND    = 3'd3,
        ST_ACK     = 3'd4,
        ST_RELEASE = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam int FRAME_BITS         = 10;
    localparam int DEF_INHIBIT_CYCLES = 2500;
    localparam int DEF_TIMEOUT_CYCLES = 50000;

    // Frame is shifted out LSB first: data[7:0], odd parity, stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command request / status bundle between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;

    // A command byte is taken on any clk25 edge where tx_valid and tx_ready are
    // both high; tx_data must be stable while tx_valid is high. tx_ready is only
    // high in IDLE, and requests presented while busy are dropped, not queued.
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       timeout;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  ack_ok,
        input  timeout
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output ack_ok,
        output timeout
    );

endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchronizer plus falling-edge detector for one PS/2 pin.
// Shared between the host transmitter and the keyboard receiver.
module ps2_line_sync (
    input  logic clk25,
    input  logic rst,
    input  logic pin_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = pin_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the clock, issues a
// request-to-send, shifts one byte out on device clock edges and reports ACK/NACK/timeout.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic         clk25,
    input  logic         rst,
    ps2_host_tx_if.slave tx_if,
    input  logic         ps2_clk_i,
    input  logic         ps2_data_i,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe,
    output state_t       dbg_state
);

    localparam int TIMER_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         LAST_BIT     = 4'(FRAME_BITS - 1);
    localparam logic [3:0]         BIT_CNT_MAX  = 4'(FRAME_BITS);

    logic clk_sync;
    logic clk_fall;
    logic data_sync;
    logic data_fall_unused;

    ps2_line_sync u_clk_sync (
        .clk25  (clk25),
        .rst    (rst),
        .pin_i  (ps2_clk_i),
        .sync_o (clk_sync),
        .fall_o (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk25  (clk25),
        .rst    (rst),
        .pin_i  (ps2_data_i),
        .sync_o (data_sync),
        .fall_o (data_fall_unused)
    );

    state_t                  state_q,   state_d;
    logic [TIMER_W-1:0]      timer_q,   timer_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   frame_q,   frame_d;
    logic                    clk_oe_q,  clk_oe_d;
    logic                    data_oe_q, data_oe_d;
    logic                    ack_ok_q,  ack_ok_d;
    logic                    timeout_q, timeout_d;

    logic inhibit_over;
    logic timer_expired;

    assign inhibit_over  = (timer_q == INHIBIT_LAST);
    assign timer_expired = (timer_q == TIMEOUT_LAST);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ack_ok_d  = ack_ok_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (tx_if.tx_valid) begin
                    frame_d   = build_frame(tx_if.tx_data);
                    bit_cnt_d = '0;
                    timer_d   = '0;
                    ack_ok_d  = 1'b0;
                    timeout_d = 1'b0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (inhibit_over) begin
                    data_oe_d = 1'b1;
                    timer_d   = '0;
                    state_d   = ST_REQ;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_REQ: begin
                clk_oe_d = 1'b0;
                timer_d  = '0;
                state_d  = ST_SEND;
            end

            // An edge arriving in the expiry cycle wins over the timeout.
            ST_SEND: begin
                if (clk_fall) begin
                    data_oe_d = ~frame_q[0];
                    frame_d   = {1'b0, frame_q[FRAME_BITS-1:1]};
                    bit_cnt_d = (bit_cnt_q == BIT_CNT_MAX) ? bit_cnt_q : bit_cnt_q + 1'b1;
                    timer_d   = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_ACK;
                    end
                end else if (timer_expired) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    ack_ok_d  = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_ACK: begin
                if (clk_fall) begin
                    ack_ok_d = ~data_sync;
                    timer_d  = '0;
                    state_d  = ST_RELEASE;
                end else if (timer_expired) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    ack_ok_d  = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (clk_sync && data_sync) begin
                    state_d = ST_DONE;
                end else if (timer_expired) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    ack_ok_d  = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Async reset drops both output enables the moment rst rises.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ack_ok_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ack_ok_q  <= ack_ok_d;
            timeout_q <= timeout_d;
        end
    end

    assign tx_if.tx_ready = (state_q == ST_IDLE) && !rst;
    assign tx_if.busy     = (state_q != ST_IDLE);
    assign tx_if.done     = (state_q == ST_DONE);
    assign tx_if.ack_ok   = ack_ok_q;
    assign tx_if.timeout  = timeout_q;
    assign ps2_clk_oe     = clk_oe_q;
    assign ps2_data_oe    = data_oe_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on open-drain lines, a table of
// command bytes with hand-computed frames, and directed timeout/reset/hold sequences.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH  = 50;
    localparam int TMO  = 400;
    localparam int HALF = 20;

    logic   clk25    = 1'b0;
    logic   rst      = 1'b1;
    logic   dev_clk  = 1'b1;
    logic   dev_data = 1'b1;
    logic   ps2_clk_i;
    logic   ps2_data_i;
    logic   ps2_clk_oe;
    logic   ps2_data_oe;
    state_t dbg_state;

    ps2_host_tx_if tx_if ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk25       (clk25),
        .rst         (rst),
        .tx_if       (tx_if),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .dbg_state   (dbg_state)
    );

    // Open-drain wiring: either side can pull a line low.
    assign ps2_clk_i  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_i = dev_data & ~ps2_data_oe;

    // ---------------- clock / reset ----------------
    always #20 clk25 = ~clk25;

    int cyc = 0;
    always @(posedge clk25) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    int   done_cnt       = 0;
    int   acc_cnt        = 0;
    int   ready_busy_cnt = 0;
    int   done_cyc       = 0;
    logic last_ack       = 1'b0;
    logic last_to        = 1'b0;
    logic prev_busy      = 1'b0;

    always @(negedge clk25) begin
        if (tx_if.done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            last_ack <= tx_if.ack_ok;
            last_to  <= tx_if.timeout;
        end
        if (tx_if.busy === 1'b1 && !prev_busy) acc_cnt <= acc_cnt + 1;
        if (tx_if.busy === 1'b1 && tx_if.tx_ready === 1'b1) ready_busy_cnt <= ready_busy_cnt + 1;
        prev_busy <= (tx_if.busy === 1'b1);
    end

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int last_fall_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic request(input logic [7:0] d, input string tag, input bit hold);
        @(negedge clk25);
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        chk({tag, "_ready"}, tx_if.tx_ready, 1);
        @(negedge clk25);
        chk({tag, "_busy"}, tx_if.busy, 1);
        if (!hold) tx_if.tx_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag, input int lo);
        int len  = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (ps2_clk_oe) seen = 1'b1;
            else @(negedge clk25);
        end
        chk({tag, "_req_seen"}, seen, 1);
        while (ps2_clk_oe && len < INH + 20) begin
            len++;
            @(negedge clk25);
        end
        chk_rng({tag, "_inhibit_len"}, len, lo, INH + 2);
        chk({tag, "_start_bit"}, ps2_data_oe, 1);
        repeat (HALF) @(negedge clk25);
    endtask

    task automatic dev_pulse(output logic smp);
        dev_clk       = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk25);
        dev_clk = 1'b1;
        smp     = ps2_data_i;
        repeat (HALF) @(negedge clk25);
    endtask

    task automatic shift_frame(output logic [9:0] bits);
        logic b;
        for (int i = 0; i < 10; i++) begin
            dev_pulse(b);
            bits[i] = b;
        end
    endtask

    task automatic ack_edge(input bit ack);
        logic b;
        dev_data = ack ? 1'b0 : 1'b1;
        dev_pulse(b);
        dev_data = 1'b1;
    endtask

    task automatic finish_xfer(input string tag, input int start, input bit exp_ack,
                               input bit exp_to, input int bound, input bit idle_after);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk25);
            if (done_cnt != start) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, seen, 1);
        repeat (3) @(negedge clk25);
        chk({tag, "_ack_ok"}, last_ack, exp_ack);
        chk({tag, "_timeout"}, last_to, exp_to);
        chk({tag, "_one_done"}, done_cnt - start, 1);
        if (idle_after) begin
            chk({tag, "_clk_oe_rel"}, ps2_clk_oe, 0);
            chk({tag, "_data_oe_rel"}, ps2_data_oe, 0);
            chk({tag, "_ready_after"}, tx_if.tx_ready, 1);
            chk({tag, "_ack_hold"}, tx_if.ack_ok, exp_ack);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        bit         dev_ack;
        logic [9:0] exp_bits;
        bit         exp_ack;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vector(input int idx);
        string      tag;
        int         start;
        logic [9:0] bits;
        tag   = $sformatf("v%0d", idx);
        start = done_cnt;
        request(vecs[idx].data, tag, 1'b0);
        wait_req(tag, INH);
        shift_frame(bits);
        chk({tag, "_bits"}, bits, vecs[idx].exp_bits);
        ack_edge(vecs[idx].dev_ack);
        finish_xfer(tag, start, vecs[idx].exp_ack, 1'b0, 50, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         start;
        int         a0;
        int         rb0;
        int         fall;
        logic       b;
        logic [9:0] bits;

        // {data, device acks, sampled bits {stop,parity,data}, expected ack_ok}
        vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1'b1};
        vecs[1] = '{8'hF4, 1'b1, 10'h2F4, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 10'h300, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 10'h3FF, 1'b0};
        vecs[4] = '{8'h55, 1'b1, 10'h355, 1'b1};
        vecs[5] = '{8'h01, 1'b1, 10'h201, 1'b1};

        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b0;

        repeat (3) @(negedge clk25);
        chk("rst_ready_low", tx_if.tx_ready, 0);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        rst = 1'b0;
        @(negedge clk25);
        chk("reset_ready", tx_if.tx_ready, 1);
        chk("reset_busy", tx_if.busy, 0);
        chk("reset_done", tx_if.done, 0);
        chk("reset_ack_ok", tx_if.ack_ok, 0);
        chk("reset_timeout", tx_if.timeout, 0);
        chk("reset_data_oe", ps2_data_oe, 0);

        for (int i = 0; i < 6; i++) run_vector(i);

        // Device stops clocking after the fourth edge.
        start = done_cnt;
        request(8'hA5, "to", 1'b0);
        wait_req("to", INH);
        repeat (4) dev_pulse(b);
        fall = last_fall_cyc;
        finish_xfer("to", start, 1'b0, 1'b1, TMO + 50, 1'b1);
        chk_rng("to_latency", done_cyc - fall, TMO + 2, TMO + 4);

        // Reset while the sixth data bit is on the line.
        start = done_cnt;
        request(8'h1F, "rs", 1'b0);
        wait_req("rs", INH);
        repeat (5) dev_pulse(b);
        dev_clk = 1'b0;
        repeat (5) @(negedge clk25);
        chk("rs_data_oe_pre", ps2_data_oe, 1);
        rst = 1'b1;
        #1;
        chk("rs_clk_oe", ps2_clk_oe, 0);
        chk("rs_data_oe", ps2_data_oe, 0);
        chk("rs_ready_low", tx_if.tx_ready, 0);
        @(negedge clk25);
        dev_clk = 1'b1;
        @(negedge clk25);
        rst = 1'b0;
        @(negedge clk25);
        chk("rs_ready_after", tx_if.tx_ready, 1);
        chk("rs_busy_after", tx_if.busy, 0);
        repeat (5) @(negedge clk25);
        chk("rs_no_done", done_cnt - start, 0);
        run_vector(0);

        // tx_valid held high across a transfer and into the next one.
        start = done_cnt;
        a0    = acc_cnt;
        rb0   = ready_busy_cnt;
        request(8'hF4, "hv", 1'b1);
        wait_req("hv", INH);
        shift_frame(bits);
        chk("hv_bits", bits, 10'h2F4);
        ack_edge(1'b1);
        finish_xfer("hv", start, 1'b1, 1'b0, 50, 1'b0);
        chk("hv_reaccept_busy", tx_if.busy, 1);
        chk("hv_accepts_first", acc_cnt - a0, 2);
        tx_if.tx_valid = 1'b0;
        wait_req("hv2", INH - 4);
        shift_frame(bits);
        chk("hv2_bits", bits, 10'h2F4);
        ack_edge(1'b1);
        finish_xfer("hv2", start + 1, 1'b1, 1'b0, 50, 1'b1);
        chk("hv_accepts_total", acc_cnt - a0, 2);
        chk("hv_ready_while_busy", ready_busy_cnt - rb0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
